sel_n_rr: RTL and testbench
===========================

Name: sel_n_rr

Overview:
- Parametrised N-channel, W-bit registered selector. Successor to the combinational 4-to-1 selector.
- Adds valid/ready handshakes on every input and on the output, plus a one-deep output register.
- Two modes:
  - Fixed: channel chosen by SEL_IN, as in the 4-to-1 selector.
  - Round-robin: fair arbitration among valid channels.
- Sits between N producer streams and a single consumer.

Parameters:
- N, 4, number of input channels (2..16).
- W, 8, data width per channel.
- SW, 2, select/pointer width; must equal ceil(log2(N)).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IN_DATA  input  N*W  channel i occupies bits [i*W +: W].
- IN_VALID  input  N  per-channel data valid.
- IN_READY  output  N  per-channel accept; at most one bit set per cycle.
- MODE  input  1  0 = fixed select, 1 = round-robin.
- SEL_IN  input  SW  channel index used in fixed mode.
- OUT_DATA  output  W  registered selected data.
- OUT_CH  output  SW  index of the channel that produced OUT_DATA.
- OUT_VALID  output  1  output register holds a beat.
- OUT_READY  input  1  consumer accepts the beat.

Behaviour:
- Reset (RST_N low, asynchronous):
  - OUT_VALID=0, OUT_DATA=0, OUT_CH=0, round-robin pointer PTR=0.
  - IN_READY=0 while reset is held.
  - Any beat in flight is discarded.
- free = !OUT_VALID | OUT_READY (combinational).
- Grant, combinational, one channel g per cycle:
  - Fixed mode: g = SEL_IN if SEL_IN < N and IN_VALID[SEL_IN]=1; otherwise no grant. An out-of-range SEL_IN never grants.
  - Round-robin mode: g = first channel with IN_VALID=1, searching PTR, PTR+1, ..., N-1, 0, ..., PTR-1 (wrap modulo N). No valid channel means no grant.
- IN_READY[g] = free & grant exists; all other IN_READY bits are 0. IN_READY depends on IN_VALID, so it is combinational from the inputs.
- Transfer on channel g when IN_VALID[g] & IN_READY[g]. On the next edge:
  - OUT_DATA <= IN_DATA[g].
  - OUT_CH <= g.
  - OUT_VALID <= 1.
- Latency is 1 cycle from input acceptance to OUT_VALID.
- free but no grant: OUT_VALID <= 0 at the edge. OUT_DATA and OUT_CH hold their previous values.
- OUT_VALID=1 and OUT_READY=0:
  - All outputs hold.
  - No IN_READY is asserted.
  - OUT_DATA and OUT_CH must not change.
- OUT_READY=1 together with a new grant in the same cycle: new beat loaded. Full throughput is 1 beat per cycle.
- PTR:
  - Updated only on a round-robin transfer: PTR <= (g+1) mod N.
  - Wraps from N-1 to 0.
  - Unchanged in fixed mode.
- MODE and SEL_IN are sampled combinationally each cycle. A change affects only the next grant, never the beat already held in the output register.

Optional Feature:
- Macro: SEL_N_RR_HOLD_EN
- With the macro defined:
  - Extra port IN_LAST (input, N bits) marks the final beat of a packet per channel.
  - In round-robin mode, once channel g transfers a beat with IN_LAST[g]=0, the arbiter locks onto g. Other channels get no grant even if g deasserts IN_VALID.
  - The lock ends after the transfer of a beat with IN_LAST[g]=1; PTR then becomes (g+1) mod N.
  - PTR is not advanced on locked non-last beats.
  - Lock is cleared by reset and when MODE=0. Fixed mode ignores IN_LAST.
- Without the macro: IN_LAST does not exist and arbitration is per beat.

Test Plan (N=4, W=8):
- Fixed select: MODE=0, SEL_IN=2, IN_VALID=4'b1111, IN_DATA ch2=8'hA5, OUT_READY=1 -> IN_READY=4'b0100; next cycle OUT_DATA=8'hA5, OUT_CH=2, OUT_VALID=1.
- Round-robin fairness: MODE=1, IN_VALID=4'b1111 held, OUT_READY=1 for 8 cycles -> OUT_CH sequence 0,1,2,3,0,1,2,3; PTR wraps 3->0.
- Sparse round-robin: MODE=1, IN_VALID=4'b1010, PTR=0 -> grants ch1 then ch3 then ch1; ch0 and ch2 never get IN_READY.
- Backpressure: OUT_READY=0 after one beat (OUT_DATA=8'h3C) for 5 cycles -> OUT_DATA stays 8'h3C, OUT_VALID=1, IN_READY=4'b0000. OUT_READY=1 -> next beat loads the same cycle it is accepted.
- Out-of-range/idle: MODE=0 with SEL_IN pointed at an idle channel (IN_VALID bit 0) -> no IN_READY; OUT_VALID drops to 0 after the held beat drains.
- Reset mid-stream: RST_N low while OUT_VALID=1 -> OUT_VALID, OUT_DATA, OUT_CH go 0 without a clock edge. After release, first round-robin grant is ch0. With SEL_N_RR_HOLD_EN defined, also check that a 3-beat packet on ch1 blocks ch2 until IN_LAST.

Source files
------------

// File: rtl/sel_n_rr.sv
// N-channel registered selector with fixed-select and round-robin modes and a one-deep output register.
// Optional packet hold (lock onto a channel until IN_LAST) is built when SEL_N_RR_HOLD_EN is defined.
module sel_n_rr #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = 2
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [N*W-1:0] IN_DATA,
  input  logic [N-1:0]   IN_VALID,
  output logic [N-1:0]   IN_READY,
`ifdef SEL_N_RR_HOLD_EN
  input  logic [N-1:0]   IN_LAST,
`endif
  input  logic           MODE,
  input  logic [SW-1:0]  SEL_IN,
  output logic [W-1:0]   OUT_DATA,
  output logic [SW-1:0]  OUT_CH,
  output logic           OUT_VALID,
  input  logic           OUT_READY
);

  // Handshake: a beat moves on channel i when IN_VALID[i] & IN_READY[i] at a rising edge,
  // and leaves the output register when OUT_VALID & OUT_READY at a rising edge.

  logic          free;
  logic          grant_any;
  logic          xfer;
  logic          last_beat;
  logic [SW-1:0] grant_idx;
  logic [SW-1:0] ptr;
  logic [SW-1:0] ptr_next;
  logic [W-1:0]  grant_data;

`ifdef SEL_N_RR_HOLD_EN
  logic          lock_on;
  logic [SW-1:0] lock_ch;
`endif

  assign free = !OUT_VALID | OUT_READY;
  // Gating with RST_N keeps every IN_READY low while reset is held.
  assign xfer = free & grant_any & RST_N;
  assign ptr_next = (grant_idx == SW'(N-1)) ? '0 : grant_idx + SW'(1);

  always_comb begin
    int j;
    j         = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    if (!MODE) begin
      // Comparing against each in-range index means an out-of-range SEL_IN never grants.
      for (int i = 0; i < N; i++) begin
        if (SEL_IN == SW'(i) && IN_VALID[i]) begin
          grant_any = 1'b1;
          grant_idx = SW'(i);
        end
      end
    end
`ifdef SEL_N_RR_HOLD_EN
    else if (lock_on) begin
      grant_any = IN_VALID[lock_ch];
      grant_idx = lock_ch;
    end
`endif
    else begin
      // Walk offsets from farthest to nearest so the channel closest to ptr wins.
      for (int k = N - 1; k >= 0; k--) begin
        j = int'(ptr) + k;
        if (j >= N) j = j - N;
        if (IN_VALID[j]) begin
          grant_any = 1'b1;
          grant_idx = SW'(j);
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    IN_READY   = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SW'(i)) begin
        grant_data  = IN_DATA[i*W +: W];
        IN_READY[i] = xfer;
      end
    end
  end

`ifdef SEL_N_RR_HOLD_EN
  assign last_beat = IN_LAST[grant_idx];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lock_on <= 1'b0;
      lock_ch <= '0;
    end else if (!MODE) begin
      lock_on <= 1'b0;
    end else if (xfer) begin
      lock_on <= !last_beat;
      lock_ch <= grant_idx;
    end
  end
`else
  assign last_beat = 1'b1;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_CH    <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        OUT_DATA  <= grant_data;
        OUT_CH    <= grant_idx;
        OUT_VALID <= 1'b1;
      end else if (free) begin
        OUT_VALID <= 1'b0;
      end
      // The pointer moves past a channel only once its packet (or single beat) is done.
      if (xfer && MODE && last_beat) ptr <= ptr_next;
    end
  end

endmodule

// File: tb/tb_sel_n_rr.sv
// Bench for sel_n_rr: directed literal checks plus randomized traffic against a behavioural model.
// Define SEL_N_RR_HOLD_EN to exercise the packet-hold build.
module tb_sel_n_rr;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           CLK;
  logic           RST_N;
  logic [N*W-1:0] IN_DATA;
  logic [N-1:0]   IN_VALID;
  logic [N-1:0]   IN_READY;
`ifdef SEL_N_RR_HOLD_EN
  logic [N-1:0]   IN_LAST;
`endif
  logic           MODE;
  logic [SW-1:0]  SEL_IN;
  logic [W-1:0]   OUT_DATA;
  logic [SW-1:0]  OUT_CH;
  logic           OUT_VALID;
  logic           OUT_READY;

  sel_n_rr #(.N(N), .W(W), .SW(SW)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .IN_DATA(IN_DATA),
    .IN_VALID(IN_VALID),
    .IN_READY(IN_READY),
`ifdef SEL_N_RR_HOLD_EN
    .IN_LAST(IN_LAST),
`endif
    .MODE(MODE),
    .SEL_IN(SEL_IN),
    .OUT_DATA(OUT_DATA),
    .OUT_CH(OUT_CH),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  // behavioural model state
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data  = '0;
  int           m_ch    = 0;
  int           m_ptr   = 0;
  logic         m_lock  = 1'b0;
  int           m_lock_ch = 0;

  int           c_g;
  logic         c_free;
  logic [N-1:0] c_rdy;
  logic         c_last;

  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] got_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0; m_lock = 1'b0; m_lock_ch = 0;
  endtask

  // Grant from the rules: fixed picks SEL_IN if valid; round-robin scans ptr, ptr+1, ... mod N.
  function automatic int model_grant();
    if (!MODE) return (int'(SEL_IN) < N && IN_VALID[SEL_IN]) ? int'(SEL_IN) : -1;
    if (m_lock) return IN_VALID[m_lock_ch] ? m_lock_ch : -1;
    for (int k = 0; k < N; k++)
      if (IN_VALID[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // compare process
  always @(negedge CLK) begin
    if (RST_N && chk_en) begin
      check("out_valid", 32'(OUT_VALID), 32'(m_valid));
      check("out_data",  32'(OUT_DATA),  32'(m_data));
      check("out_ch",    32'(OUT_CH),    32'(m_ch));
      c_g    = model_grant();
      c_free = !m_valid || OUT_READY;
      c_rdy  = '0;
      if (c_free && c_g >= 0) c_rdy[c_g] = 1'b1;
      check("in_ready", 32'(IN_READY), 32'(c_rdy));
`ifdef SEL_N_RR_HOLD_EN
      c_last = (c_g >= 0) ? IN_LAST[c_g] : 1'b1;
`else
      c_last = 1'b1;
`endif
      if (c_free && c_g >= 0) begin
        m_valid = 1'b1;
        m_data  = IN_DATA[c_g*W +: W];
        m_ch    = c_g;
        if (MODE) begin
          m_lock    = !c_last;
          m_lock_ch = c_g;
          if (c_last) m_ptr = (c_g + 1) % N;
        end
      end else if (c_free) begin
        m_valid = 1'b0;
      end
      if (!MODE) m_lock = 1'b0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0; MODE = 1'b0; SEL_IN = '0; OUT_READY = 1'b1;
    IN_VALID = 4'b1111; IN_DATA = '0;
`ifdef SEL_N_RR_HOLD_EN
    IN_LAST = '1;
`endif
    #2;
    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("rst_out_data",  32'(OUT_DATA),  32'd0);
    check("rst_out_ch",    32'(OUT_CH),    32'd0);
    check("rst_in_ready",  32'(IN_READY),  32'd0);
    tick(); tick();
    RST_N = 1'b1;
    model_reset();
    chk_en = 1'b1;

    // fixed select of channel 2
    MODE = 1'b0; SEL_IN = 2'd2; IN_VALID = 4'b1111;
    IN_DATA = {8'h33, 8'hA5, 8'h11, 8'h00};
    #1 check("fix_ready", 32'(IN_READY), 32'b0100);
    tick();
    check("fix_data",  32'(OUT_DATA),  32'hA5);
    check("fix_ch",    32'(OUT_CH),    32'd2);
    check("fix_valid", 32'(OUT_VALID), 32'd1);

    // round-robin fairness over all four channels
    MODE = 1'b1; IN_VALID = 4'b1111;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    for (int i = 0; i < 8; i++) begin
      IN_DATA = $urandom;
      tick();
      got_q.push_back(OUT_CH);
    end
    for (int i = 0; i < 8; i++) check("rr_seq", 32'(got_q[i]), 32'(exp_q[i]));

    // sparse round-robin: only ch1 and ch3 valid
    IN_VALID = 4'b1010;
    #1 check("sparse_rdy0", 32'(IN_READY), 32'b0010);
    tick(); check("sparse_ch0", 32'(OUT_CH), 32'd1);
    #1 check("sparse_rdy1", 32'(IN_READY), 32'b1000);
    tick(); check("sparse_ch1", 32'(OUT_CH), 32'd3);
    #1 check("sparse_rdy2", 32'(IN_READY), 32'b0010);
    tick(); check("sparse_ch2", 32'(OUT_CH), 32'd1);

    // backpressure holds the 3C beat
    MODE = 1'b0; SEL_IN = 2'd0; IN_VALID = 4'b0001; IN_DATA = 32'h0000_003C;
    tick();
    OUT_READY = 1'b0; IN_DATA = 32'h0000_00EE;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ready", 32'(IN_READY),  32'd0);
      check("bp_data",  32'(OUT_DATA),  32'h3C);
      check("bp_valid", 32'(OUT_VALID), 32'd1);
      tick();
    end
    OUT_READY = 1'b1; IN_DATA = 32'h0000_005A;
    #1 check("bp_release_rdy", 32'(IN_READY), 32'b0001);
    tick(); check("bp_next_data", 32'(OUT_DATA), 32'h5A);

    // fixed select pointed at an idle channel
    SEL_IN = 2'd2;
    #1 check("idle_ready", 32'(IN_READY), 32'd0);
    tick(); check("idle_valid", 32'(OUT_VALID), 32'd0);

    // reset in the middle of a stream
    MODE = 1'b1; IN_VALID = 4'b1111; IN_DATA = 32'hDEAD_BEEF;
    tick(); check("pre_rst_valid", 32'(OUT_VALID), 32'd1);
    RST_N = 1'b0;
    #1;
    check("mid_rst_valid", 32'(OUT_VALID), 32'd0);
    check("mid_rst_data",  32'(OUT_DATA),  32'd0);
    check("mid_rst_ch",    32'(OUT_CH),    32'd0);
    check("mid_rst_ready", 32'(IN_READY),  32'd0);
    model_reset();
    RST_N = 1'b1;
    #1 check("post_rst_ready", 32'(IN_READY), 32'b0001);
    tick(); check("post_rst_ch", 32'(OUT_CH), 32'd0);

`ifdef SEL_N_RR_HOLD_EN
    // 3-beat packet on ch1 blocks ch2 until its last beat
    IN_VALID = 4'b0110; IN_LAST = 4'b0000;
    #1 check("hold_b0", 32'(IN_READY), 32'b0010);
    tick();
    #1 check("hold_b1", 32'(IN_READY), 32'b0010);
    tick();
    IN_VALID = 4'b0100;
    #1 check("hold_gap", 32'(IN_READY), 32'd0);
    tick();
    IN_VALID = 4'b0110; IN_LAST = 4'b0010;
    #1 check("hold_last", 32'(IN_READY), 32'b0010);
    tick();
    IN_LAST = 4'b0000;
    #1 check("hold_after", 32'(IN_READY), 32'b0100);
    tick();
`endif

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      MODE      = ($urandom_range(0, 3) != 0);
      SEL_IN    = SW'($urandom_range(0, N-1));
      IN_VALID  = N'($urandom);
      IN_DATA   = $urandom;
      OUT_READY = ($urandom_range(0, 3) != 0);
`ifdef SEL_N_RR_HOLD_EN
      IN_LAST   = N'($urandom);
`endif
      if ($urandom_range(0, 199) == 0) begin
        RST_N = 1'b0;
        #1 model_reset();
        RST_N = 1'b1;
      end
      tick();
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
